// File: rtl/riscv_insn_types.sv
// Shared RV32I decode types for the decode controller.
//   insn_type_e    : decoded instruction format
//   out_state_e    : occupancy of the registered output stage
//   dec_fields_t   : bundle of decoded fields held in the output stage
//   OPC_*          : recognised major opcodes
//   opcode_type()  : major opcode -> format
//   imm_decode()   : format + insn[31:7] -> sign-extended immediate
package riscv_insn_types;

  typedef enum logic [2:0] {
    INSN_R       = 3'd0,
    INSN_I       = 3'd1,
    INSN_S       = 3'd2,
    INSN_B       = 3'd3,
    INSN_U       = 3'd4,
    INSN_J       = 3'd5,
    INSN_ILLEGAL = 3'd6
  } insn_type_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    insn_type_e  typ;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } dec_fields_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic insn_type_e opcode_type(input logic [6:0] opc);
    case (opc)
      OPC_OP:                                      return INSN_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:  return INSN_I;
      OPC_STORE:                                   return INSN_S;
      OPC_BRANCH:                                  return INSN_B;
      OPC_LUI, OPC_AUIPC:                          return INSN_U;
      OPC_JAL:                                     return INSN_J;
      default:                                     return INSN_ILLEGAL;
    endcase
  endfunction

  // Takes insn[31:7] with its natural bit numbering so the format
  // tables below read the same as the ISA manual.
  function automatic logic [31:0] imm_decode(input insn_type_e t,
                                             input logic [31:7] h);
    case (t)
      INSN_I:  return {{20{h[31]}}, h[31:20]};
      INSN_S:  return {{20{h[31]}}, h[31:25], h[11:7]};
      INSN_B:  return {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
      INSN_U:  return {h[31:12], 12'b0};
      INSN_J:  return {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_decode_ctrl_if.sv
// Handshake bundle between fetch, the decode controller and execute.
//   in_valid/in_insn/in_ready : fetch-side raw instruction handshake
//   flush                     : discard everything held
//   out_valid/out_ready       : execute-side handshake
//   out_*                     : decoded fields
// slave  : view used by the decode controller
// master : view used by the surrounding pipeline (or a bench)
interface riscv_decode_ctrl_if;
  import riscv_insn_types::*;

  logic        in_valid;
  logic [31:0] in_insn;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  insn_type_e  out_type;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_insn, flush, out_ready,
    output in_ready, out_valid, out_type, out_opcode, out_rd, out_rs1,
           out_rs2, out_funct3, out_funct7, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_insn, flush, out_ready,
    input  in_ready, out_valid, out_type, out_opcode, out_rd, out_rs1,
           out_rs2, out_funct3, out_funct7, out_imm, out_illegal
  );

endinterface

// File: rtl/riscv_insn_field_extract.sv
// Purely combinational RV32I field extraction.
//   i_insn      : raw 32-bit instruction
//   o_type      : decoded format (INSN_ILLEGAL for unknown opcodes)
//   o_opcode..  : raw register/function fields, always extracted R-style
//   o_imm       : sign-extended immediate (0 for R and ILLEGAL)
//   o_illegal   : opcode not recognised
module riscv_insn_field_extract
  import riscv_insn_types::*;
(
  input  logic [31:0] i_insn,
  output insn_type_e  o_type,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_imm,
  output logic        o_illegal
);

  insn_type_e w_type;

  assign w_type    = opcode_type(i_insn[6:0]);
  assign o_type    = w_type;
  assign o_opcode  = i_insn[6:0];
  assign o_rd      = i_insn[11:7];
  assign o_funct3  = i_insn[14:12];
  assign o_rs1     = i_insn[19:15];
  assign o_rs2     = i_insn[24:20];
  assign o_funct7  = i_insn[31:25];
  assign o_imm     = imm_decode(w_type, i_insn[31:7]);
  assign o_illegal = (w_type == INSN_ILLEGAL);

endmodule

// File: rtl/riscv_decode_ctrl.sv
// Decode controller: raw-instruction FIFO plus one registered stage of
// decoded fields.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch/execute handshakes and decoded outputs (slave view)
// QDEPTH is the FIFO depth (2 or 4); with the output stage the block
// holds at most QDEPTH+1 instructions.
//
// Output stage state:
//   state     | meaning
//   OUT_EMPTY | no decoded instruction held, out_valid low
//   OUT_FULL  | decoded fields held, out_valid high until taken
module riscv_decode_ctrl
  import riscv_insn_types::*;
#(
  parameter int QDEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  riscv_decode_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QDEPTH);

  logic [31:0]      r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rdy_en;
  out_state_e       r_state;
  out_state_e       w_state_nxt;
  dec_fields_t      r_out;

  logic        w_in_ready;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_out_free;
  logic        w_fifo_empty;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic [31:0] w_sel_insn;
  dec_fields_t w_dec;

  insn_type_e  w_type;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm;
  logic        w_illegal;

  // r_rdy_en keeps in_ready low until the first edge after reset release.
  assign w_fifo_empty = (r_count == '0);
  assign w_in_ready   = r_rdy_en && !bus.flush && (r_count < CNT_MAX);
  assign w_in_xfer    = bus.in_valid && w_in_ready;
  assign w_out_xfer   = (r_state == OUT_FULL) && bus.out_ready;
  assign w_out_free   = (r_state == OUT_EMPTY) || w_out_xfer;
  assign w_bypass     = w_in_xfer && w_fifo_empty && w_out_free;
  assign w_push       = w_in_xfer && !w_bypass;
  assign w_pop        = !bus.flush && w_out_free && !w_fifo_empty;
  assign w_load       = w_bypass || w_pop;

  // When the FIFO holds anything its head is older than the input.
  assign w_sel_insn = w_fifo_empty ? bus.in_insn : r_mem[r_rd_ptr];

  riscv_insn_field_extract u_extract (
    .i_insn    (w_sel_insn),
    .o_type    (w_type),
    .o_opcode  (w_opcode),
    .o_rd      (w_rd),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_funct3  (w_funct3),
    .o_funct7  (w_funct7),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  assign w_dec = {w_type, w_opcode, w_rd, w_rs1, w_rs2, w_funct3,
                  w_funct7, w_imm, w_illegal};

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_insn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= OUT_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Flush wins over any load or transfer in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush)       w_state_nxt = OUT_EMPTY;
    else if (w_load)     w_state_nxt = OUT_FULL;
    else if (w_out_xfer) w_state_nxt = OUT_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out <= '0;
    else if (w_load) r_out <= w_dec;
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == OUT_FULL);
  assign bus.out_type    = r_out.typ;
  assign bus.out_opcode  = r_out.opcode;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_rs1     = r_out.rs1;
  assign bus.out_rs2     = r_out.rs2;
  assign bus.out_funct3  = r_out.funct3;
  assign bus.out_funct7  = r_out.funct7;
  assign bus.out_imm     = r_out.imm;
  assign bus.out_illegal = r_out.illegal;

endmodule

// File: tb/tb_riscv_decode_ctrl.sv
// Bench for riscv_decode_ctrl: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// queue-based model of the instructions held by the block.
module tb_riscv_decode_ctrl;
  import riscv_insn_types::*;

  localparam int QDEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_decode_ctrl_if bus ();

  riscv_decode_ctrl #(.QDEPTH(QDEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: every instruction held (output stage first), oldest first.
  logic [31:0] mq[$];
  bit          rdy_en = 1'b0;
  bit          m_ir, m_ix, m_ox, exp_ir;

  task automatic chk(input string name, input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [67:0] ref_fields(input logic [31:0] x);
    insn_type_e  t;
    logic [31:0] imm;
    logic [12:0] b;
    logic [20:0] j;
    case (x[6:0])
      7'h33:                      t = INSN_R;
      7'h13, 7'h03, 7'h67, 7'h73: t = INSN_I;
      7'h23:                      t = INSN_S;
      7'h63:                      t = INSN_B;
      7'h37, 7'h17:               t = INSN_U;
      7'h6F:                      t = INSN_J;
      default:                    t = INSN_ILLEGAL;
    endcase
    b = {x[31], x[7], x[30:25], x[11:8], 1'b0};
    j = {x[31], x[19:12], x[20], x[30:21], 1'b0};
    case (t)
      INSN_I:  imm = 32'($signed(x) >>> 20);
      INSN_S:  imm = (32'($signed(x) >>> 20) & ~32'h1F) | {27'b0, x[11:7]};
      INSN_B:  imm = {{19{b[12]}}, b};
      INSN_U:  imm = x & 32'hFFFF_F000;
      INSN_J:  imm = {{11{j[20]}}, j};
      default: imm = 32'h0;
    endcase
    return {t, x[6:0], x[11:7], x[19:15], x[24:20], x[14:12], x[31:25],
            imm, (t == INSN_ILLEGAL)};
  endfunction

  function automatic logic [67:0] dut_fields();
    return {bus.out_type, bus.out_opcode, bus.out_rd, bus.out_rs1,
            bus.out_rs2, bus.out_funct3, bus.out_funct7, bus.out_imm,
            bus.out_illegal};
  endfunction

  // addi xk, x0, 0 : rd identifies each instruction in directed tests
  function automatic logic [31:0] mk(input int k);
    return 32'h13 | (32'(k) << 7);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      rdy_en = 1'b0;
    end else begin
      m_ir = rdy_en && !bus.flush && (mq.size() <= QDEPTH);
      m_ix = bus.in_valid && m_ir;
      m_ox = (mq.size() > 0) && bus.out_ready;
      if (bus.flush) mq.delete();
      else begin
        if (m_ox) void'(mq.pop_front());
        if (m_ix) mq.push_back(bus.in_insn);
      end
      rdy_en = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready",  68'(bus.in_ready),  68'(0));
      chk("rst_out_valid", 68'(bus.out_valid), 68'(0));
      chk("rst_fields",    dut_fields(),       68'(0));
    end else begin
      exp_ir = rdy_en && !bus.flush && (mq.size() <= QDEPTH);
      chk("in_ready",  68'(bus.in_ready),  68'(exp_ir));
      chk("out_valid", 68'(bus.out_valid), 68'(mq.size() > 0));
      if (mq.size() > 0) chk("fields", dut_fields(), ref_fields(mq[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic send1(input logic [31:0] insn);
    step();
    bus.in_valid = 1'b1;
    bus.in_insn  = insn;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_burst(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.in_valid = 1'b1;
      bus.in_insn  = mk(base + i);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  logic [6:0] opc_pool [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00};
  logic [31:0] r32;
  bit [3:0]    exp_rdy4;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_insn   = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) look();
    chk("reset_in_ready", 68'(bus.in_ready), 68'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    look();
    chk("ready_held_after_reset", 68'(bus.in_ready), 68'(0));
    look();
    chk("ready_after_reset", 68'(bus.in_ready), 68'(1));

    // add a0,a0,a1
    bus.out_ready = 1'b1;
    send1(32'h00B50533);
    look();
    chk("add_valid",  68'(bus.out_valid),  68'(1));
    chk("add_type",   68'(bus.out_type),   68'(INSN_R));
    chk("add_rd",     68'(bus.out_rd),     68'(10));
    chk("add_rs1",    68'(bus.out_rs1),    68'(10));
    chk("add_rs2",    68'(bus.out_rs2),    68'(11));
    chk("add_funct7", 68'(bus.out_funct7), 68'(0));
    chk("add_imm",    68'(bus.out_imm),    68'(0));

    // addi x1,x0,-1
    send1(32'hFFF00093);
    look();
    chk("addi_type", 68'(bus.out_type), 68'(INSN_I));
    chk("addi_imm",  68'(bus.out_imm),  68'(32'hFFFF_FFFF));
    chk("addi_rd",   68'(bus.out_rd),   68'(1));
    look();
    chk("addi_taken", 68'(bus.out_valid), 68'(0));

    // four back-to-back inputs against a stalled consumer
    bus.out_ready = 1'b0;
    exp_rdy4 = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.in_valid = 1'b1;
      bus.in_insn  = mk(i + 1);
      look();
      chk("stall_in_ready", 68'(bus.in_ready), 68'(exp_rdy4[i]));
    end
    step();
    bus.in_valid = 1'b0;
    look();
    chk("stall_hold_a", dut_fields(), ref_fields(mk(1)));
    look();
    chk("stall_hold_b", dut_fields(), ref_fields(mk(1)));
    step();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      look();
      chk("drain_valid", 68'(bus.out_valid), 68'(1));
      chk("drain_rd",    68'(bus.out_rd),    68'(k));
    end
    look();
    chk("drain_done", 68'(bus.out_valid), 68'(0));

    // full FIFO with continuous input and output traffic
    step();
    bus.out_ready = 1'b0;
    push_burst(5, 3);
    bus.in_valid  = 1'b1;
    bus.in_insn   = mk(8);
    bus.out_ready = 1'b1;
    look();
    chk("full_rdy0", 68'(bus.in_ready), 68'(0));
    chk("full_rd0",  68'(bus.out_rd),   68'(5));
    step();
    look();
    chk("full_rdy1", 68'(bus.in_ready), 68'(1));
    chk("full_rd1",  68'(bus.out_rd),   68'(6));
    step();
    bus.in_insn = mk(9);
    look();
    chk("full_rdy2", 68'(bus.in_ready), 68'(1));
    chk("full_rd2",  68'(bus.out_rd),   68'(7));
    step();
    bus.in_valid = 1'b0;
    look();
    chk("full_rd3", 68'(bus.out_rd), 68'(8));
    look();
    chk("full_rd4", 68'(bus.out_rd), 68'(9));
    look();
    chk("full_done", 68'(bus.out_valid), 68'(0));

    // flush while holding three
    step();
    bus.out_ready = 1'b0;
    push_burst(10, 3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_insn  = mk(13);
    look();
    chk("flush_in_ready", 68'(bus.in_ready), 68'(0));
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    look();
    chk("flush_out_valid", 68'(bus.out_valid), 68'(0));
    chk("flush_in_ready1", 68'(bus.in_ready),  68'(1));
    send1(mk(14));
    look();
    chk("post_flush_valid", 68'(bus.out_valid), 68'(1));
    chk("post_flush_rd",    68'(bus.out_rd),    68'(14));

    // illegal opcode, then reset mid-stream
    bus.out_ready = 1'b1;
    send1(32'h0000007F);
    look();
    chk("illegal_flag", 68'(bus.out_illegal), 68'(1));
    chk("illegal_type", 68'(bus.out_type),    68'(INSN_ILLEGAL));
    bus.out_ready = 1'b0;
    push_burst(20, 2);
    look();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 68'(bus.out_valid),   68'(0));
    chk("async_rst_ready", 68'(bus.in_ready),    68'(0));
    chk("async_rst_ill",   68'(bus.out_illegal), 68'(0));
    chk("async_rst_all",   dut_fields(),         68'(0));
    step();
    step();
    rst_n = 1'b1;
    look();
    chk("rst2_ready_held", 68'(bus.in_ready), 68'(0));
    look();
    chk("rst2_ready",      68'(bus.in_ready),  68'(1));
    chk("rst2_no_replay",  68'(bus.out_valid), 68'(0));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      r32 = $urandom();
      bus.in_insn  = {r32[31:7], opc_pool[$urandom_range(11)]};
      bus.in_valid = ($urandom_range(3) != 0);
      case ((c / 500) % 3)
        0:       bus.out_ready = ($urandom_range(3) != 0);
        1:       bus.out_ready = ($urandom_range(3) == 0);
        default: bus.out_ready = $urandom_range(1) != 0;
      endcase
      bus.flush = ($urandom_range(31) == 0);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
    end
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    look();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
